// File: rtl/itoh_tsujii_sequencer.sv
// Control sequencer for an Itoh-Tsujii field inversion: a^-1 = a^126 in five multiply steps.
// Optional bank writes of intermediate betas are enabled by defining ITOH_STORE_BETA_EN.
module itoh_tsujii_sequencer #(
   parameter int unsigned AUTO_RESTART = 0,
   parameter int unsigned DONE_PULSE   = 1
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       start,
   input  logic       a_is_zero,
   output logic       busy,
   output logic       done,
   output logic       zero_err,
   output logic       en,
   output logic [1:0] sel_mux1,
   output logic [1:0] sel_mux2,
   output logic [1:0] n_cascade,
   output logic [1:0] sel_read,
   output logic [1:0] sel_write,
   output logic       store_we
);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StSq    = 3'd1,
      StMulA  = 3'd2,
      StSqMul = 3'd3,
      StCasc3 = 3'd4,
      StFinal = 3'd5,
      StDone  = 3'd6
   } state_e;

   state_e r_state;
   state_e w_state_nxt;
   logic   r_zero_err;
   logic   w_zero_err_nxt;
   logic   r_armed;
   logic   w_accept;

   // r_armed blocks a start on the first edge after reset release
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state    <= StIdle;
         r_zero_err <= 1'b0;
         r_armed    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_zero_err <= w_zero_err_nxt;
         r_armed    <= 1'b1;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_zero_err_nxt = r_zero_err;
      w_accept       = 1'b0;
      case (r_state)
         StIdle:  w_accept = start & r_armed;
         StSq:    w_state_nxt = StMulA;
         StMulA:  w_state_nxt = StSqMul;
         StSqMul: w_state_nxt = StCasc3;
         StCasc3: w_state_nxt = StFinal;
         StFinal: w_state_nxt = StDone;
         StDone: begin
            if (start) begin
               if (AUTO_RESTART != 0) begin
                  w_accept = 1'b1;
               end else begin
                  w_state_nxt = StIdle;
               end
            end else if (DONE_PULSE != 0) begin
               w_state_nxt = StIdle;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
      // A zero operand has no inverse: report it and skip the chain entirely
      if (w_accept) begin
         w_state_nxt    = a_is_zero ? StDone : StSq;
         w_zero_err_nxt = a_is_zero;
      end
   end

   always_comb begin
      en        = 1'b0;
      sel_mux1  = 2'd0;
      sel_mux2  = 2'd0;
      n_cascade = 2'd0;
      sel_read  = 2'd0;
      case (r_state)
         StSq: begin
            en = 1'b1;
         end
         StMulA: begin
            en       = 1'b1;
            sel_mux2 = 2'd2;
         end
         StSqMul: begin
            en        = 1'b1;
            sel_mux2  = 2'd1;
            n_cascade = 2'd1;
         end
         StCasc3: begin
            en        = 1'b1;
            sel_mux1  = 2'd2;
            sel_mux2  = 2'd1;
            n_cascade = 2'd3;
         end
         StFinal: begin
            en       = 1'b1;
            sel_mux1 = 2'd2;
            sel_mux2 = 2'd2;
         end
         default: ;
      endcase
   end

`ifdef ITOH_STORE_BETA_EN
   // Bank captures the result register before the same-cycle update, so each write
   // stores the previous step's beta
   always_comb begin
      store_we  = 1'b1;
      sel_write = 2'd0;
      case (r_state)
         StMulA, StSqMul: sel_write = 2'd1;
         StCasc3:         sel_write = 2'd2;
         StFinal:         sel_write = 2'd3;
         default:         store_we  = 1'b0;
      endcase
   end
`else
   assign store_we  = 1'b0;
   assign sel_write = 2'd0;
`endif

   assign busy     = r_state inside {StSq, StMulA, StSqMul, StCasc3, StFinal};
   assign done     = (r_state == StDone);
   assign zero_err = r_zero_err;

endmodule

// File: tb/tb_itoh_tsujii_sequencer.sv
// Self-checking bench: drives the sequencer into a GF(2^7) (f = x^7+x+1) datapath model and
// compares control outputs and inverses against spec-level expectations.
module tb_itoh_tsujii_sequencer;

`ifdef ITOH_STORE_BETA_EN
   localparam logic STORE = 1'b1;
`else
   localparam logic STORE = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RST_N = 1'b1;
   logic       start = 1'b0;
   logic       a_is_zero = 1'b0;
   logic       busy, done, zero_err, en, store_we;
   logic [1:0] sel_mux1, sel_mux2, n_cascade, sel_read, sel_write;

   int         n_vec = 0;
   int         n_err = 0;
   logic [6:0] dp_a = 7'h01;
   logic [6:0] dp_res = 7'h00;
   logic [6:0] bank [4];

   always #5 CLK = ~CLK;

   itoh_tsujii_sequencer dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .start     (start),
      .a_is_zero (a_is_zero),
      .busy      (busy),
      .done      (done),
      .zero_err  (zero_err),
      .en        (en),
      .sel_mux1  (sel_mux1),
      .sel_mux2  (sel_mux2),
      .n_cascade (n_cascade),
      .sel_read  (sel_read),
      .sel_write (sel_write),
      .store_we  (store_we)
   );

   function automatic logic [6:0] gf_mul(input logic [6:0] x, input logic [6:0] y);
      logic [6:0] p;
      logic [6:0] s;
      p = 7'h00;
      s = x;
      for (int i = 0; i < 7; i++) begin
         if (y[i]) p = p ^ s;
         s = s[6] ? ({s[5:0], 1'b0} ^ 7'h03) : {s[5:0], 1'b0};
      end
      return p;
   endfunction

   function automatic logic [6:0] opnd(input logic [1:0] sel, input logic [6:0] a,
                                       input logic [6:0] r, input logic [1:0] n);
      logic [6:0] c;
      c = r;
      for (int i = 0; i < int'(n); i++) c = gf_mul(c, c);
      case (sel)
         2'd0:    return a;
         2'd1:    return c;
         2'd2:    return r;
         default: return 7'h00;
      endcase
   endfunction

   function automatic logic [6:0] ref_pow(input logic [6:0] a, input int e);
      logic [6:0] r;
      r = 7'h01;
      for (int i = 0; i < e; i++) r = gf_mul(r, a);
      return r;
   endfunction

   function automatic logic [6:0] ref_inv(input logic [6:0] a);
      for (int b = 1; b < 128; b++) begin
         if (gf_mul(a, 7'(b)) == 7'h01) return 7'(b);
      end
      return 7'h00;
   endfunction

   // Expected {busy,done,en,sel_mux1,sel_mux2,store_we} for cycle i after an accepted start
   function automatic logic [7:0] exp_step(input int i);
      case (i)
         1:       return {3'b101, 2'd0, 2'd0, 1'b0};
         2:       return {3'b101, 2'd0, 2'd2, STORE};
         3:       return {3'b101, 2'd0, 2'd1, STORE};
         4:       return {3'b101, 2'd2, 2'd1, STORE};
         5:       return {3'b101, 2'd2, 2'd2, STORE};
         6:       return {3'b010, 2'd0, 2'd0, 1'b0};
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [1:0] exp_wr(input int i);
      case (i)
         2, 3:    return 2'd1;
         4:       return 2'd2;
         5:       return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   // Datapath model: result register and bank both capture on falling CLK
   always @(negedge CLK) begin
      if (store_we) bank[sel_write] <= dp_res;
      if (en) dp_res <= gf_mul(opnd(sel_mux1, dp_a, dp_res, n_cascade),
                               opnd(sel_mux2, dp_a, dp_res, n_cascade));
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Entry and exit: 1 time unit after an edge, FSM in IDLE
   task automatic run_inv(input logic [6:0] a, input bit noise);
      logic [7:0] exp_v;
      logic [7:0] obs_v;
      dp_a      = a;
      a_is_zero = 1'b0;
      start     = 1'b1;
      tick();
      for (int i = 1; i <= 6; i++) begin
         exp_v = exp_step(i);
         obs_v = {busy, done, en, sel_mux1, sel_mux2, store_we};
         n_vec++;
         if (obs_v !== exp_v) begin
            n_err++;
            $display("FAIL step%0d a=%h {busy,done,en,m1,m2,we}: got %b want %b",
                     i, a, obs_v, exp_v);
         end
         n_vec++;
         if (zero_err !== 1'b0) begin
            n_err++;
            $display("FAIL zero_err_run%0d a=%h: got %b want 0", i, a, zero_err);
         end
         if (exp_v[0] || STORE == 1'b0) begin
            n_vec++;
            if (sel_write !== exp_wr(i) && exp_v[0]) begin
               n_err++;
               $display("FAIL sel_write%0d a=%h: got %0d want %0d", i, a, sel_write, exp_wr(i));
            end else if (!exp_v[0] && sel_write !== 2'd0) begin
               n_err++;
               $display("FAIL sel_write_tied%0d: got %0d want 0", i, sel_write);
            end
         end
         if (i == 3 || i == 4) begin
            n_vec++;
            if (n_cascade !== ((i == 3) ? 2'd1 : 2'd3)) begin
               n_err++;
               $display("FAIL n_cascade%0d a=%h: got %0d want %0d", i, a, n_cascade,
                        (i == 3) ? 1 : 3);
            end
         end
         if (i == 6) begin
            n_vec++;
            if (dp_res !== ref_inv(a) || gf_mul(dp_res, a) !== 7'h01) begin
               n_err++;
               $display("FAIL inverse a=%h: got %h want %h", a, dp_res, ref_inv(a));
            end
         end
         start = 1'b0;
         if (noise) begin
            start     = 1'($urandom);
            a_is_zero = 1'($urandom);
         end
         tick();
      end
      start     = 1'b0;
      a_is_zero = 1'b0;
      n_vec++;
      if ({busy, done, en, store_we, sel_mux1, sel_mux2, n_cascade, sel_read} !== 12'h000) begin
         n_err++;
         $display("FAIL idle_after a=%h: got busy=%b done=%b en=%b we=%b m1=%0d m2=%0d nc=%0d rd=%0d want all 0",
                  a, busy, done, en, store_we, sel_mux1, sel_mux2, n_cascade, sel_read);
      end
   endtask

   task automatic test_reset();
      RST_N = 1'b1;
      #2 RST_N = 1'b0;
      #1;
      n_vec++;
      if ({busy, done, zero_err, en, store_we, sel_mux1, sel_mux2, n_cascade, sel_read,
           sel_write} !== 15'h0) begin
         n_err++;
         $display("FAIL reset_async: got busy=%b done=%b zerr=%b en=%b we=%b want all 0",
                  busy, done, zero_err, en, store_we);
      end
      repeat (2) @(posedge CLK);
      #1;
      n_vec++;
      if ({busy, done, zero_err, en, store_we} !== 5'h0) begin
         n_err++;
         $display("FAIL reset_held: got busy=%b done=%b zerr=%b en=%b want all 0",
                  busy, done, zero_err, en);
      end
      RST_N = 1'b1;
      start = 1'b1;
      tick();
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_err++;
         $display("FAIL first_edge_start: got busy=%b done=%b want 0 0", busy, done);
      end
      start = 1'b0;
      tick();
      n_vec++;
      if (busy !== 1'b0 || en !== 1'b0) begin
         n_err++;
         $display("FAIL idle_after_release: got busy=%b en=%b want 0 0", busy, en);
      end
   endtask

   task automatic test_zero();
      logic [6:0] res_before;
      res_before = dp_res;
      dp_a       = 7'($urandom);
      a_is_zero  = 1'b1;
      start      = 1'b1;
      tick();
      start     = 1'b0;
      a_is_zero = 1'b0;
      n_vec++;
      if ({busy, done, zero_err, en, sel_mux1, sel_mux2} !== 8'b01100000) begin
         n_err++;
         $display("FAIL zero_done: got busy=%b done=%b zerr=%b en=%b want 0 1 1 0",
                  busy, done, zero_err, en);
      end
      tick();
      n_vec++;
      if ({busy, done, zero_err, en} !== 4'b0010 || dp_res !== res_before) begin
         n_err++;
         $display("FAIL zero_idle: got busy=%b done=%b zerr=%b en=%b res=%h want 0 0 1 0 res=%h",
                  busy, done, zero_err, en, dp_res, res_before);
      end
   endtask

   task automatic test_midreset();
      // Reset in DONE after a zero operand: zero_err drops immediately
      a_is_zero = 1'b1;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      a_is_zero = 1'b0;
      #2 RST_N = 1'b0;
      #1;
      n_vec++;
      if ({done, zero_err} !== 2'b00) begin
         n_err++;
         $display("FAIL reset_in_done: got done=%b zerr=%b want 0 0", done, zero_err);
      end
      @(posedge CLK);
      #1 RST_N = 1'b1;
      tick();
      dp_a  = 7'($urandom_range(1, 127));
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      n_vec++;
      if (en !== 1'b1 || n_cascade !== 2'd3 || sel_mux1 !== 2'd2) begin
         n_err++;
         $display("FAIL reach_casc3: got en=%b nc=%0d m1=%0d want 1 3 2", en, n_cascade, sel_mux1);
      end
      #2 RST_N = 1'b0;
      #1;
      n_vec++;
      if ({busy, done, zero_err, en, store_we, sel_mux1, sel_mux2, n_cascade, sel_read,
           sel_write} !== 15'h0) begin
         n_err++;
         $display("FAIL reset_mid_chain: got busy=%b done=%b en=%b m1=%0d m2=%0d nc=%0d want all 0",
                  busy, done, en, sel_mux1, sel_mux2, n_cascade);
      end
      @(posedge CLK);
      #1 RST_N = 1'b1;
      tick();
      run_inv(7'($urandom_range(1, 127)), 1'b0);
   endtask

   task automatic test_store();
      logic [6:0] exp_b [4];
      for (int i = 0; i < 4; i++) bank[i] = 7'h00;
      run_inv(7'h02, 1'b0);
      exp_b[0] = 7'h00;
`ifdef ITOH_STORE_BETA_EN
      exp_b[1] = ref_pow(7'h02, 3);
      exp_b[2] = ref_pow(7'h02, 7);
      exp_b[3] = ref_pow(7'h02, 63);
`else
      exp_b[1] = 7'h00;
      exp_b[2] = 7'h00;
      exp_b[3] = 7'h00;
`endif
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if (bank[i] !== exp_b[i]) begin
            n_err++;
            $display("FAIL bank%0d: got %h want %h", i, bank[i], exp_b[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int a = 1; a < 128; a++) begin
         run_inv(7'(a), ($urandom_range(0, 3) == 0));
      end
   endtask

   task automatic test_ignore_start();
      for (int k = 0; k < 20; k++) begin
         run_inv(7'($urandom_range(1, 127)), 1'b1);
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) bank[i] = 7'h00;
      test_reset();
      run_inv(7'h1B, 1'b0);
      test_zero();
      run_inv(7'h1B, 1'b0);
      test_midreset();
      test_store();
      test_back_to_back();
      test_ignore_start();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: bench did not reach its summary within the time limit");
      $fatal(1, "timeout");
   end

endmodule
